// File: rtl/mul_pkg.sv
// Shared definitions for the sequential RV32M multiply unit:
// op encodings, sequencer states and iteration count.
package mul_pkg;

    localparam int DATA_W   = 32;
    localparam int ITER_CNT = 32;

    localparam logic [4:0] LAST_ITER = 5'(ITER_CNT - 1);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_e;

    function automatic logic a_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic b_signed(input logic [1:0] op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups,
// group carries chained between groups.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 8; k++) begin : grp
        logic [3:0] gi;
        logic [3:0] pi;
        logic       ci;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       co;

        assign gi = g[4*k +: 4];
        assign pi = p[4*k +: 4];

        if (k == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = grp[k-1].co;
        end

        assign c1 = gi[0] | (pi[0] & ci);
        assign c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        assign c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                  | (pi[2] & pi[1] & pi[0] & ci);
        assign co = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
                  | (pi[3] & pi[2] & pi[1] & gi[0]) | ((&pi) & ci);

        assign sum[4*k +: 4] = pi ^ {c3, c2, c1, ci};
    end

    assign cout = grp[7].co;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiplier: abs, 32 shift-add steps, 64-bit negate,
// all arithmetic time-shared on a single cla32 instance.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag
);

    state_e state_q;
    state_e state_d;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;
    logic [1:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              sa_q;
    logic              sb_q;
    logic              neg_q;
    logic              cy_q;
    logic [4:0]        cnt_q;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    logic req_sa;
    logic req_sb;

    assign req_sa = req_a[31] & a_signed(req_op);
    assign req_sb = req_b[31] & b_signed(req_op);

    cla32 u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder operand steering; idle states feed zeros so the adder stays quiet.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            S_ABS_A: begin
                add_a   = ~a_q;
                add_cin = 1'b1;
            end
            S_ABS_B: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            S_ITER: begin
                add_a = hi_q;
                add_b = lo_q[0] ? a_q : '0;
            end
            S_NEG_LO: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            S_NEG_HI: begin
                add_a   = ~hi_q;
                add_cin = cy_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_valid) state_d = S_ABS_A;
            S_ABS_A:  state_d = S_ABS_B;
            S_ABS_B:  state_d = S_ITER;
            S_ITER:   if (cnt_q == LAST_ITER) state_d = S_NEG_LO;
            S_NEG_LO: state_d = S_NEG_HI;
            S_NEG_HI: state_d = S_DONE;
            S_DONE:   if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            op_q  <= '0;
            tag_q <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            neg_q <= 1'b0;
            cy_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_a;
                        lo_q  <= req_b;
                        hi_q  <= '0;
                        op_q  <= req_op;
                        tag_q <= req_tag;
                        sa_q  <= req_sa;
                        sb_q  <= req_sb;
                        neg_q <= req_sa ^ req_sb;
                        cy_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                S_ABS_A: begin
                    if (sa_q) a_q <= add_sum;
                end
                S_ABS_B: begin
                    if (sb_q) lo_q <= add_sum;
                    hi_q  <= '0;
                    cnt_q <= '0;
                end
                S_ITER: begin
                    hi_q  <= {add_cout, add_sum[31:1]};
                    lo_q  <= {add_sum[0], lo_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                end
                S_NEG_LO: begin
                    if (neg_q) {cy_q, lo_q} <= {add_cout, add_sum};
                    else       cy_q <= 1'b0;
                end
                S_NEG_HI: begin
                    if (neg_q) hi_q <= add_sum;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_tag   = tag_q;
    assign res_data  = !res_valid         ? '0
                     : (op_q == OP_MUL)   ? lo_q
                     :                      hi_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner cases,
// kill/reset scenarios and a randomized run against a 64-bit product model.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        kill;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .kill      (kill),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Full 64-bit product of the sign- or zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        kill      = 1'b0;
        check("busy_ready", req_ready, 0);
    endtask

    // Called in cycle 1 after acceptance; returns cycle index of res_valid.
    task automatic wait_res(input bit junk, output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 60) begin
            if (junk) begin
                req_valid = $urandom_range(0, 1) == 1;
                req_op    = 2'($urandom);
                req_a     = $urandom;
                req_b     = $urandom;
                req_tag   = 5'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [31:0] exp, input logic [4:0] tag,
                             input int hold, input bit junk);
        int cyc;
        wait_res(junk, cyc);
        check("latency", cyc, 37);
        check("res_data", res_data, exp);
        check("res_tag", res_tag, tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp);
            check("hold_tag", res_tag, tag);
            check("hold_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("drain_valid", res_valid, 0);
        check("drain_ready", req_ready, 1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int hold, input bit junk);
        start_op(op, a, b, tag);
        finish_op(exp, tag, hold, junk);
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        kill      = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_tag", res_tag, 0);
        rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'd6, 5'd3, 32'h0000_002A, 0, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 0, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 5, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd0, 5'd6, 32'h0000_0000, 0, 0);

        // kill during ITER (count 10 is cycle 13)
        start_op(2'b00, 32'd1234, 32'd5678, 5'd9);
        repeat (12) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_iter_valid", res_valid, 0);
        check("kill_iter_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("kill_no_result", seen, 0);
        run_op(2'b00, 32'd3, 32'd5, 5'd7, 32'd15, 0, 0);

        // kill in DONE wins over res_ready
        start_op(2'b11, 32'd10, 32'd20, 5'd8);
        wait_res(0, cyc);
        check("kill_done_latency", cyc, 37);
        kill      = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        kill      = 1'b0;
        res_ready = 1'b0;
        check("kill_done_valid", res_valid, 0);
        check("kill_done_ready", req_ready, 1);

        // kill while idle does not block acceptance
        kill = 1'b1;
        run_op(2'b00, 32'd2, 32'd2, 5'd10, 32'd4, 0, 0);

        // async reset in ITER
        start_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ready", req_ready, 1);
        check("arst_valid", res_valid, 0);
        check("arst_tag", res_tag, 0);
        check("arst_data", res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("arst_no_result", seen, 0);

        for (int n = 0; n < 900; n++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  tag;
            op  = 2'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            tag = 5'($urandom);
            run_op(op, a, b, tag, model(op, a, b), $urandom_range(0, 2),
                   $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
